// File: rtl/weight_stream_manager.sv
// weight_stream_manager: optionally writes a host weight package to DDR through the DataMover,
// then reads it back REPEAT times towards the PE array, chunked by MAX_BTT.
module weight_stream_manager #(
    parameter int DW      = 128,
    parameter int ADDR_W  = 32,
    parameter int MAX_BTT = 4194304,
    parameter int REP_W   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_axis_cfg_tvalid,
    output logic          s_axis_cfg_tready,
    input  logic [31:0]   s_axis_cfg_tdata,
    input  logic          s_axis_weight_tvalid,
    output logic          s_axis_weight_tready,
    input  logic [DW-1:0] s_axis_weight_tdata,
    output logic          m_axis_s2mm_tvalid,
    input  logic          m_axis_s2mm_tready,
    output logic [DW-1:0] m_axis_s2mm_tdata,
    output logic          m_axis_s2mm_tlast,
    output logic          m_axis_s2mm_cmd_tvalid,
    input  logic          m_axis_s2mm_cmd_tready,
    output logic [71:0]   m_axis_s2mm_cmd_tdata,
    output logic          m_axis_mm2s_cmd_tvalid,
    input  logic          m_axis_mm2s_cmd_tready,
    output logic [71:0]   m_axis_mm2s_cmd_tdata,
    input  logic          s_axis_mm2s_tvalid,
    output logic          s_axis_mm2s_tready,
    input  logic [DW-1:0] s_axis_mm2s_tdata,
    output logic          m_axis_weight_tvalid,
    input  logic          m_axis_weight_tready,
    output logic [DW-1:0] m_axis_weight_tdata,
    output logic [2:0]    status,
    output logic          done
);
    localparam int BPB = DW / 8;
    localparam int LB  = $clog2(BPB);
    localparam int BCW = ADDR_W - LB;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CFG    = 3'd1,
        W_CMD  = 3'd2,
        W_DATA = 3'd3,
        R_CMD  = 3'd4,
        R_DATA = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t           state, state_n;
    logic [1:0]       word;
    logic             src;
    logic [REP_W-1:0] rep, rep_in, pass_cnt;
    logic [ADDR_W-1:0] w_addr, r_addr, addr;
    logic [31:0]      len, len_in, rem;
    logic [22:0]      btt;
    logic [BCW-1:0]   beat;
    logic [3:0]       tag;
    logic             cmd_valid;
    logic             in_cmd, cfg_hs, cmd_hs, beat_hs, last_beat, chunk_end, more, pass_more;
    logic [71:0]      cmd;

    assign in_cmd    = state == W_CMD || state == R_CMD;
    assign cfg_hs    = s_axis_cfg_tvalid && s_axis_cfg_tready;
    assign cmd_hs    = cmd_valid && (state == W_CMD ? m_axis_s2mm_cmd_tready : m_axis_mm2s_cmd_tready);
    assign beat_hs   = (state == W_DATA && s_axis_weight_tvalid && m_axis_s2mm_tready) ||
                       (state == R_DATA && s_axis_mm2s_tvalid && m_axis_weight_tready);
    assign len_in    = s_axis_cfg_tdata & ~32'(BPB - 1);
    assign rep_in    = s_axis_cfg_tdata[REP_W+25:26] == '0 ? REP_W'(1) : s_axis_cfg_tdata[REP_W+25:26];
    // rem only shrinks at chunk end, so btt stays constant across a command and its data beats
    assign btt       = rem > 32'(MAX_BTT) ? 23'(MAX_BTT) : rem[22:0];
    assign more      = rem != {9'h0, btt};
    assign last_beat = 32'(beat) == 32'(btt >> LB) - 32'd1;
    assign chunk_end = beat_hs && last_beat;
    assign pass_more = pass_cnt + REP_W'(1) < rep;
    assign cmd       = {4'h0, tag, 32'(addr), 1'b0, 1'b1, 6'h0, 1'b1, btt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = CFG;
            CFG:     if (cfg_hs && word == 2'd3) state_n = len_in == '0 ? DONE : (src ? R_CMD : W_CMD);
            W_CMD:   if (cmd_hs) state_n = W_DATA;
            W_DATA:  if (chunk_end) state_n = more ? W_CMD : R_CMD;
            R_CMD:   if (cmd_hs) state_n = R_DATA;
            R_DATA:  if (chunk_end) state_n = (more || pass_more) ? R_CMD : DONE;
            DONE:    state_n = CFG;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= '0;
            src       <= 1'b0;
            rep       <= '0;
            pass_cnt  <= '0;
            w_addr    <= '0;
            r_addr    <= '0;
            addr      <= '0;
            len       <= '0;
            rem       <= '0;
            beat      <= '0;
            tag       <= '0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= in_cmd && !cmd_hs;
            if (cfg_hs) begin
                word <= word + 2'd1;
                if (word == 2'd0) begin
                    src <= s_axis_cfg_tdata[25];
                    rep <= rep_in;
                end
                if (word == 2'd1) w_addr <= ADDR_W'(s_axis_cfg_tdata);
                if (word == 2'd2) r_addr <= ADDR_W'(s_axis_cfg_tdata);
                if (word == 2'd3) begin
                    len      <= len_in;
                    rem      <= len_in;
                    addr     <= src ? r_addr : w_addr;
                    tag      <= '0;
                    pass_cnt <= '0;
                    beat     <= '0;
                end
            end
            if (beat_hs) beat <= last_beat ? '0 : beat + BCW'(1);
            // end of the write phase and every read pass both restart the chunk walk at r_addr
            if (chunk_end) begin
                if (more) begin
                    rem  <= rem - {9'h0, btt};
                    addr <= addr + ADDR_W'(btt);
                    tag  <= tag + 4'd1;
                end else begin
                    rem  <= len;
                    addr <= r_addr;
                    tag  <= '0;
                    if (state == R_DATA) pass_cnt <= pass_cnt + REP_W'(1);
                end
            end
        end
    end

    assign s_axis_cfg_tready      = state == CFG;
    assign m_axis_s2mm_tvalid     = s_axis_weight_tvalid && state == W_DATA;
    assign s_axis_weight_tready   = m_axis_s2mm_tready && state == W_DATA;
    assign m_axis_s2mm_tdata      = s_axis_weight_tdata;
    assign m_axis_s2mm_tlast      = state == W_DATA && last_beat;
    assign m_axis_weight_tvalid   = s_axis_mm2s_tvalid && state == R_DATA;
    assign s_axis_mm2s_tready     = m_axis_weight_tready && state == R_DATA;
    assign m_axis_weight_tdata    = s_axis_mm2s_tdata;
    assign m_axis_s2mm_cmd_tvalid = cmd_valid && state == W_CMD;
    assign m_axis_mm2s_cmd_tvalid = cmd_valid && state == R_CMD;
    assign m_axis_s2mm_cmd_tdata  = cmd;
    assign m_axis_mm2s_cmd_tdata  = cmd;
    assign status                 = state;
    assign done                   = state == DONE;

endmodule

// File: tb/tb_weight_stream_manager.sv
// tb_weight_stream_manager: table-driven and randomized package runs against a DDR/DataMover
// model; expected commands and output beats come from the chunking rules with plain arithmetic.
module tb_weight_stream_manager;
    localparam int DW   = 128;
    localparam int BPB  = 16;
    localparam int MAXB = 64;

    logic          clk = 1'b0, rst = 1'b1;
    logic          s_axis_cfg_tvalid, s_axis_cfg_tready;
    logic [31:0]   s_axis_cfg_tdata;
    logic          s_axis_weight_tvalid, s_axis_weight_tready;
    logic [DW-1:0] s_axis_weight_tdata;
    logic          m_axis_s2mm_tvalid, m_axis_s2mm_tready, m_axis_s2mm_tlast;
    logic [DW-1:0] m_axis_s2mm_tdata;
    logic          m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tready;
    logic [71:0]   m_axis_s2mm_cmd_tdata;
    logic          m_axis_mm2s_cmd_tvalid, m_axis_mm2s_cmd_tready;
    logic [71:0]   m_axis_mm2s_cmd_tdata;
    logic          s_axis_mm2s_tvalid, s_axis_mm2s_tready;
    logic [DW-1:0] s_axis_mm2s_tdata;
    logic          m_axis_weight_tvalid, m_axis_weight_tready;
    logic [DW-1:0] m_axis_weight_tdata;
    logic [2:0]    status;
    logic          done;

    weight_stream_manager #(.DW(DW), .ADDR_W(32), .MAX_BTT(MAXB), .REP_W(6)) dut (
        .clk(clk), .rst(rst),
        .s_axis_cfg_tvalid(s_axis_cfg_tvalid), .s_axis_cfg_tready(s_axis_cfg_tready),
        .s_axis_cfg_tdata(s_axis_cfg_tdata),
        .s_axis_weight_tvalid(s_axis_weight_tvalid), .s_axis_weight_tready(s_axis_weight_tready),
        .s_axis_weight_tdata(s_axis_weight_tdata),
        .m_axis_s2mm_tvalid(m_axis_s2mm_tvalid), .m_axis_s2mm_tready(m_axis_s2mm_tready),
        .m_axis_s2mm_tdata(m_axis_s2mm_tdata), .m_axis_s2mm_tlast(m_axis_s2mm_tlast),
        .m_axis_s2mm_cmd_tvalid(m_axis_s2mm_cmd_tvalid), .m_axis_s2mm_cmd_tready(m_axis_s2mm_cmd_tready),
        .m_axis_s2mm_cmd_tdata(m_axis_s2mm_cmd_tdata),
        .m_axis_mm2s_cmd_tvalid(m_axis_mm2s_cmd_tvalid), .m_axis_mm2s_cmd_tready(m_axis_mm2s_cmd_tready),
        .m_axis_mm2s_cmd_tdata(m_axis_mm2s_cmd_tdata),
        .s_axis_mm2s_tvalid(s_axis_mm2s_tvalid), .s_axis_mm2s_tready(s_axis_mm2s_tready),
        .s_axis_mm2s_tdata(s_axis_mm2s_tdata),
        .m_axis_weight_tvalid(m_axis_weight_tvalid), .m_axis_weight_tready(m_axis_weight_tready),
        .m_axis_weight_tdata(m_axis_weight_tdata),
        .status(status), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        src;
        int        rep;
        int        len;
        bit [31:0] waddr;
        bit [31:0] raddr;
        bit        stall;
        int        nw;
        int        nr;
        int        nbeats;
    } vec_t;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [71:0]  exp_w[$], exp_r[$];
    logic [127:0] host_q[$], exp_out[$];
    logic [127:0] mem [bit [31:0]];
    logic [127:0] ref_mem [bit [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_valids"}, {125'h0, m_axis_s2mm_tvalid, m_axis_s2mm_cmd_tvalid, m_axis_mm2s_cmd_tvalid}, 0);
        chk({name, "_out"}, {125'h0, m_axis_weight_tvalid, m_axis_s2mm_tlast, done}, 0);
        chk({name, "_readies"}, {125'h0, s_axis_cfg_tready, s_axis_weight_tready, s_axis_mm2s_tready}, 0);
        chk({name, "_status"}, status, 0);
    endtask

    function automatic bit go(input bit stall);
        return !stall || $urandom_range(3) != 0;
    endfunction

    task automatic push_cmds(input bit wr, input bit [31:0] base, input int len);
        logic [71:0] c;
        int b;
        int idx = 0;
        for (int off = 0; off < len; off += MAXB) begin
            b = (len - off < MAXB) ? len - off : MAXB;
            c = {4'h0, idx[3:0], base + off[31:0], 1'b0, 1'b1, 6'h0, 1'b1, b[22:0]};
            if (wr) exp_w.push_back(c);
            else exp_r.push_back(c);
            idx++;
        end
    endtask

    task automatic run_pkg(input vec_t v, input int abort_beats);
        logic [31:0]  cfg [4];
        logic [71:0]  c;
        logic [127:0] d;
        bit [31:0]    wr_ptr, rd_ptr;
        int passes, len, nb, cfg_idx, wr_left, rd_left, nw, nr, nout, ndone, w3_cyc, done_cyc, limit, t;
        bit aborted;
        passes = v.rep == 0 ? 1 : v.rep;
        len    = v.len / BPB * BPB;
        nb     = len / BPB;
        cfg[0] = (32'(v.rep) << 26) | (32'(v.src) << 25) | ($urandom & 32'h01FF_FFFF);
        cfg[1] = v.waddr;
        cfg[2] = v.raddr;
        cfg[3] = v.len;
        mem.delete(); ref_mem.delete();
        exp_w.delete(); exp_r.delete(); host_q.delete(); exp_out.delete();
        for (int i = 0; i < nb; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            mem[v.raddr / BPB + i] = d;
            ref_mem[v.raddr / BPB + i] = d;
        end
        if (!v.src) begin
            for (int i = 0; i < nb; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                host_q.push_back(d);
                ref_mem[v.waddr / BPB + i] = d;
            end
            push_cmds(1'b1, v.waddr, len);
        end
        if (len > 0)
            for (int p = 0; p < passes; p++) begin
                push_cmds(1'b0, v.raddr, len);
                for (int i = 0; i < nb; i++) exp_out.push_back(ref_mem[v.raddr / BPB + i]);
            end
        cfg_idx = 0; wr_left = 0; rd_left = 0; wr_ptr = 0; rd_ptr = 0;
        nw = 0; nr = 0; nout = 0; ndone = 0; w3_cyc = -1; done_cyc = -1; t = 0; aborted = 0;
        limit = 300 + 40 * nb * (passes + 1);
        while (t < limit && !aborted && !(ndone > 0 && cyc >= done_cyc + 3)) begin
            s_axis_cfg_tvalid      = cfg_idx < 4 && go(v.stall);
            s_axis_cfg_tdata       = cfg[cfg_idx & 3];
            s_axis_weight_tvalid   = host_q.size() > 0 && go(v.stall);
            s_axis_weight_tdata    = host_q.size() > 0 ? host_q[0] : '0;
            m_axis_s2mm_tready     = go(v.stall);
            m_axis_s2mm_cmd_tready = go(v.stall);
            m_axis_mm2s_cmd_tready = go(v.stall);
            s_axis_mm2s_tvalid     = rd_left > 0 && go(v.stall);
            s_axis_mm2s_tdata      = rd_left > 0 ? mem[rd_ptr] : '0;
            m_axis_weight_tready   = go(v.stall);
            @(negedge clk);
            if (s_axis_cfg_tvalid && s_axis_cfg_tready) begin
                if (cfg_idx == 3) w3_cyc = cyc;
                cfg_idx++;
            end
            if (s_axis_weight_tvalid && s_axis_weight_tready)
                chk("s2mm_data", m_axis_s2mm_tdata, host_q.pop_front());
            if (m_axis_s2mm_tvalid && m_axis_s2mm_tready) begin
                chk("s2mm_tlast", m_axis_s2mm_tlast, wr_left == 1);
                mem[wr_ptr] = m_axis_s2mm_tdata;
                wr_ptr++;
                wr_left--;
            end
            if (m_axis_s2mm_cmd_tvalid && m_axis_s2mm_cmd_tready) begin
                c = m_axis_s2mm_cmd_tdata;
                nw++;
                chk("s2mm_cmd", c, exp_w.size() > 0 ? exp_w.pop_front() : 72'h0);
                wr_ptr = c[63:32] / BPB;
                wr_left += int'(c[22:0]) / BPB;
            end
            if (s_axis_mm2s_tvalid && s_axis_mm2s_tready) begin
                rd_ptr++;
                rd_left--;
            end
            if (m_axis_mm2s_cmd_tvalid && m_axis_mm2s_cmd_tready) begin
                c = m_axis_mm2s_cmd_tdata;
                nr++;
                chk("mm2s_cmd", c, exp_r.size() > 0 ? exp_r.pop_front() : 72'h0);
                rd_ptr = c[63:32] / BPB;
                rd_left += int'(c[22:0]) / BPB;
            end
            if (m_axis_weight_tvalid && m_axis_weight_tready) begin
                nout++;
                chk("weight_out", m_axis_weight_tdata, exp_out.size() > 0 ? exp_out.pop_front() : '0);
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (abort_beats > 0 && nout >= abort_beats) aborted = 1;
            else begin
                @(posedge clk);
                #1;
            end
            t++;
        end
        if (abort_beats > 0) chk("abort_reached", {127'h0, aborted}, 1);
        else begin
            chk("done_count", ndone, 1);
            chk("s2mm_cmds", nw, v.nw);
            chk("mm2s_cmds", nr, v.nr);
            chk("beats_out", nout, v.nbeats);
            chk("status_after", status, 1);
            if (len == 0) chk("done_latency", done_cyc - w3_cyc, 1);
        end
    endtask

    initial begin
        vec_t tbl [9];
        vec_t v;
        int   l, ch, ps;
        tbl[0] = '{1'b0, 1, 64,   32'h1000, 32'h1000,  1'b0, 1, 1,  4};
        tbl[1] = '{1'b0, 1, 96,   32'h2000, 32'h2000,  1'b1, 2, 2,  6};
        tbl[2] = '{1'b1, 3, 32,   32'h0,    32'h3000,  1'b1, 0, 3,  6};
        tbl[3] = '{1'b0, 1, 0,    32'h400,  32'h400,   1'b0, 0, 0,  0};
        tbl[4] = '{1'b1, 2, 0,    32'h0,    32'h400,   1'b1, 0, 0,  0};
        tbl[5] = '{1'b0, 0, 72,   32'h5000, 32'h5000,  1'b1, 1, 1,  4};
        tbl[6] = '{1'b0, 2, 200,  32'h6000, 32'h6000,  1'b1, 3, 6,  24};
        tbl[7] = '{1'b1, 2, 1056, 32'h0,    32'h10000, 1'b1, 0, 34, 132};
        tbl[8] = '{1'b0, 1, 64,   32'h7000, 32'h8000,  1'b0, 1, 1,  4};

        s_axis_cfg_tvalid = 1; s_axis_cfg_tdata = '0; s_axis_weight_tvalid = 1; s_axis_weight_tdata = '0;
        m_axis_s2mm_tready = 1; m_axis_s2mm_cmd_tready = 1; m_axis_mm2s_cmd_tready = 1;
        s_axis_mm2s_tvalid = 1; s_axis_mm2s_tdata = '0; m_axis_weight_tready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        s_axis_cfg_tvalid = 0; s_axis_weight_tvalid = 0; s_axis_mm2s_tvalid = 0;
        m_axis_s2mm_tready = 0; m_axis_s2mm_cmd_tready = 0; m_axis_mm2s_cmd_tready = 0; m_axis_weight_tready = 0;
        rst = 0;
        @(posedge clk);
        #1;
        chk("status_cfg", status, 1);
        chk("cfg_tready", s_axis_cfg_tready, 1);

        for (int i = 0; i < 9; i++) run_pkg(tbl[i], 0);

        for (int k = 0; k < 6; k++) begin
            v.src   = 1'($urandom_range(1));
            v.rep   = $urandom_range(0, 3);
            v.len   = $urandom_range(0, 10) * BPB + $urandom_range(0, 15);
            v.waddr = 32'($urandom_range(0, 4095)) << 4;
            v.raddr = 32'($urandom_range(0, 4095)) << 4;
            v.stall = 1'b1;
            l  = v.len / BPB * BPB;
            ch = (l + MAXB - 1) / MAXB;
            ps = v.rep == 0 ? 1 : v.rep;
            v.nw     = v.src ? 0 : ch;
            v.nr     = ch * ps;
            v.nbeats = l / BPB * ps;
            run_pkg(v, 0);
        end

        v = '{1'b1, 1, 128, 32'h0, 32'h9000, 1'b0, 0, 2, 8};
        run_pkg(v, 3);
        #2 rst = 1;
        #1;
        chk_reset("mid_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        s_axis_cfg_tvalid = 0; s_axis_weight_tvalid = 0; s_axis_mm2s_tvalid = 0;
        rst = 0;
        @(posedge clk);
        #1;
        run_pkg(tbl[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
